sound_sequencer: RTL and testbench

SOUND_SEQUENCER -- requirements
Module: sound_sequencer

---
 rtl/sound_sequencer.sv | 156 +++++++++++++++
 tb/tb_sound_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_sequencer.sv
// sound_sequencer: plays one of four sample clips from a shared sample ROM
// into the audio controller, one sample every SAMPLE_DIV clocks.
// Optional feature macro: SOUND_PREEMPT_EN (higher-priority clip aborts the
// clip in progress while it is in LOAD or WAIT).
//
// Handshake: write_audio_out is a one-cycle strobe that is only ever high
// while audio_out_allowed is high in the same cycle. The sample on the
// channel outputs is valid whenever write_audio_out is high. While the
// controller is full, the sequencer waits in PUSH and holds rom_addr and
// the channel data.
module sound_sequencer #(
    parameter int SAMPLE_DIV = 1200,
    parameter int ADDR_W     = 18,
    parameter int SAMPLE_W   = 6
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [3:0]          play_req,
    output logic                busy,
    output logic [1:0]          active_clip,
    output logic                done,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [SAMPLE_W-1:0] rom_q,
    input  logic                audio_out_allowed,
    output logic                write_audio_out,
    output logic [31:0]         left_channel_audio_out,
    output logic [31:0]         right_channel_audio_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        PUSH = 2'd3
    } state_t;

    // LOAD + (SAMPLE_DIV-2) WAIT cycles + PUSH gives SAMPLE_DIV cycles per sample
    localparam logic [10:0] WAIT_LAST = 11'(SAMPLE_DIV - 3);

    state_t              state;
    state_t              state_next;
    logic [3:0]          pending;
    logic [10:0]         counter;
    logic [31:0]         channel;
    logic [1:0]          pick_idx;
    logic                pick_valid;
    logic                preempt;
    logic                grant;
    logic [3:0]          grant_mask;
    logic                at_end;
    logic                write_en;

    // First word of each clip
    function automatic logic [ADDR_W-1:0] clip_start(input logic [1:0] idx);
        case (idx)
            2'd0:    clip_start = ADDR_W'(0);
            2'd1:    clip_start = ADDR_W'(16396);
            2'd2:    clip_start = ADDR_W'(66983);
            default: clip_start = ADDR_W'(83255);
        endcase
    endfunction

    // Last word of each clip (inclusive)
    function automatic logic [ADDR_W-1:0] clip_end(input logic [1:0] idx);
        case (idx)
            2'd0:    clip_end = ADDR_W'(16395);
            2'd1:    clip_end = ADDR_W'(66982);
            2'd2:    clip_end = ADDR_W'(83254);
            default: clip_end = ADDR_W'(137138);
        endcase
    endfunction

    // Fixed-priority pick of the pending clips: lowest index wins
    always_comb begin
        pick_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pending[i]) pick_idx = 2'(i);
        end
    end

    assign pick_valid = |pending;
    assign at_end     = (rom_addr == clip_end(active_clip));
    assign write_en   = (state == PUSH) && audio_out_allowed;

    // Preemption only during LOAD/WAIT so an in-flight write is never cut short
    always_comb begin
`ifdef SOUND_PREEMPT_EN
        preempt = ((state == LOAD) || (state == WAIT)) && pick_valid &&
                  (pick_idx < active_clip);
`else
        preempt = 1'b0;
`endif
    end

    assign grant      = ((state == IDLE) && pick_valid) || preempt;
    assign grant_mask = grant ? (4'b0001 << pick_idx) : 4'b0000;

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (pick_valid) state_next = LOAD;
            LOAD: state_next = WAIT;
            WAIT: if (counter == WAIT_LAST) state_next = PUSH;
            PUSH: if (audio_out_allowed) state_next = at_end ? IDLE : LOAD;
            default: state_next = IDLE;
        endcase
        if (preempt) state_next = LOAD;
    end

    // Request latch, address/clip tracking, pacing counter and sample capture
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pending     <= 4'b0000;
            counter     <= 11'd0;
            rom_addr    <= '0;
            active_clip <= 2'd0;
            done        <= 1'b0;
            channel     <= 32'd0;
        end else begin
            // A new request in the grant cycle re-arms the bit, so a held request loops
            pending <= (pending & ~grant_mask) | play_req;
            done    <= write_en && at_end;

            if (grant) begin
                rom_addr    <= clip_start(pick_idx);
                active_clip <= pick_idx;
            end else if (write_en) begin
                if (at_end) begin
                    rom_addr    <= '0;
                    active_clip <= 2'd0;
                end else begin
                    rom_addr <= rom_addr + ADDR_W'(1);
                end
            end

            if (state == LOAD)      counter <= 11'd0;
            else if (state == WAIT) counter <= counter + 11'd1;

            // rom_q is valid for the current address from the first WAIT cycle on
            if (state == WAIT) channel <= {rom_q, {(32 - SAMPLE_W){1'b0}}};
        end
    end

    assign busy                    = (state != IDLE);
    assign write_audio_out         = write_en;
    assign left_channel_audio_out  = channel;
    assign right_channel_audio_out = channel;

endmodule

// File: tb/tb_sound_sequencer.sv
// tb_sound_sequencer: directed sequence with randomized flow control and
// randomized request patterns, checked against a clip-table reference model.
module tb_sound_sequencer;

    localparam int SD = 3;
    localparam int AW = 18;

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic [3:0]    play_req;
    logic          busy;
    logic [1:0]    active_clip;
    logic          done;
    logic [AW-1:0] rom_addr;
    logic [5:0]    rom_q = 6'd0;
    logic          audio_out_allowed;
    logic          write_audio_out;
    logic [31:0]   left_channel_audio_out;
    logic [31:0]   right_channel_audio_out;

    sound_sequencer #(.SAMPLE_DIV(SD), .ADDR_W(AW), .SAMPLE_W(6)) dut (
        .CLOCK_50                (CLOCK_50),
        .reset                   (reset),
        .play_req                (play_req),
        .busy                    (busy),
        .active_clip             (active_clip),
        .done                    (done),
        .rom_addr                (rom_addr),
        .rom_q                   (rom_q),
        .audio_out_allowed       (audio_out_allowed),
        .write_audio_out         (write_audio_out),
        .left_channel_audio_out  (left_channel_audio_out),
        .right_channel_audio_out (right_channel_audio_out)
    );

    // Clock
    always #5 CLOCK_50 = ~CLOCK_50;

    int starts[4] = '{0, 16396, 66983, 83255};
    int ends[4]   = '{16395, 66982, 83254, 137138};

    int            tests = 0;
    int            failed = 0;
    int            cyc = 0;
    logic [AW-1:0] exp_q[$];
    logic          armed = 1'b0;
    logic          end_expected = 1'b0;
    int            due = 0;
    int            last_wr = -100;
    int            writes = 0;

    function automatic logic [5:0] rom_f(input int a);
        return 6'((a * 37) ^ (a >> 4));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Registered sample ROM model
    always @(posedge CLOCK_50) rom_q <= rom_f(int'(rom_addr));

    // Scoreboard: write timing, address order, sample data, done pulse
    always @(negedge CLOCK_50) begin
        logic [AW-1:0] ea;
        logic          exp_w;
        chk("lr_equal", 64'(left_channel_audio_out), 64'(right_channel_audio_out));
        chk("done_pulse", 64'(done), 64'(cyc == last_wr + 1));
        if (armed) begin
            exp_w = (cyc >= due) && audio_out_allowed;
            chk("write_timing", 64'(write_audio_out), 64'(exp_w));
            if (write_audio_out) begin
                chk("queue_nonempty", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    ea = exp_q.pop_front();
                    chk("write_addr", 64'(rom_addr), 64'(ea));
                    chk("write_data", 64'(left_channel_audio_out),
                        64'({rom_f(int'(ea)), 26'd0}));
                    writes++;
                    due = cyc + SD;
                    if (exp_q.size() == 0) begin
                        armed = 1'b0;
                        if (end_expected) last_wr = cyc;
                    end
                end
            end
        end
    end

    initial begin
        logic [3:0]    req;
        logic [AW-1:0] stall_addr;
        logic          got_done;
        logic          found;
        int            idx;

        reset = 1'b1;
        play_req = 4'b1111;
        audio_out_allowed = 1'b1;
        stall_addr = '0;
        found = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_addr", 64'(rom_addr), 64'(0));
        chk("rst_clip", 64'(active_clip), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_write", 64'(write_audio_out), 64'(0));
        chk("rst_left", 64'(left_channel_audio_out), 64'(0));
        reset = 1'b0;
        play_req = 4'b0000;
        repeat (5) begin
            tick();
            chk("rst_req_ignored", 64'(busy), 64'(0));
        end

        // Full detect clip with random back-pressure, one long stall, cheer queued
        exp_q.delete();
        for (int a = starts[2]; a <= ends[2]; a++) exp_q.push_back(AW'(a));
        end_expected = 1'b1;
        writes = 0;
        play_req = 4'b0100;
        tick();
        play_req = 4'b0000;
        tick();
        chk("detect_start_addr", 64'(rom_addr), 64'(starts[2]));
        chk("detect_clip", 64'(active_clip), 64'(2));
        chk("detect_busy", 64'(busy), 64'(1));
        due = cyc + SD - 1;
        armed = 1'b1;
        got_done = 1'b0;
        for (int k = 0; k < 60000 && !got_done; k++) begin
            if (k < 300)      audio_out_allowed = ($urandom_range(0, 4) != 0);
            else if (k < 310) audio_out_allowed = 1'b0;
            else              audio_out_allowed = 1'b1;
            play_req = (k == 50) ? 4'b1000 : 4'b0000;
            if (k == 304) stall_addr = rom_addr;
            if (k > 304 && k < 310) begin
                chk("stall_addr_hold", 64'(rom_addr), 64'(stall_addr));
                chk("stall_no_write", 64'(write_audio_out), 64'(0));
            end
            tick();
            if (done) got_done = 1'b1;
        end
        audio_out_allowed = 1'b1;
        chk("detect_done", 64'(done), 64'(1));
        chk("detect_end_busy", 64'(busy), 64'(0));
        chk("detect_end_addr", 64'(rom_addr), 64'(0));
        chk("detect_end_clip", 64'(active_clip), 64'(0));
        chk("detect_writes", 64'(writes), 64'(ends[2] - starts[2] + 1));
        chk("detect_queue_empty", 64'(exp_q.size()), 64'(0));
        end_expected = 1'b0;
        armed = 1'b0;

        // Queued cheer starts right after detect's done
        tick();
        chk("cheer_start_addr", 64'(rom_addr), 64'(starts[3]));
        chk("cheer_clip", 64'(active_clip), 64'(3));
        chk("cheer_busy", 64'(busy), 64'(1));
        exp_q.delete();
        for (int a = starts[3]; a < starts[3] + 100; a++) exp_q.push_back(AW'(a));
        due = cyc + SD - 1;
        armed = 1'b1;
        repeat (20) tick();

`ifdef SOUND_PREEMPT_EN
        armed = 1'b0;
        play_req = 4'b0001;
        tick();
        play_req = 4'b0000;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (rom_addr == '0 && active_clip == 2'd0 && busy) found = 1'b1;
        end
        chk("preempt_win_grant", 64'(found), 64'(1));
`else
        play_req = 4'b0001;
        tick();
        play_req = 4'b0000;
        repeat (30) begin
            tick();
            chk("no_preempt_clip", 64'(active_clip), 64'(3));
            chk("no_preempt_range", 64'(rom_addr >= AW'(starts[3]) && rom_addr < AW'(starts[3] + 100)), 64'(1));
        end
`endif
        armed = 1'b0;

        // Reset mid-clip while stalled with requests pending
        play_req = 4'b0010;
        tick();
        play_req = 4'b0000;
        audio_out_allowed = 1'b0;
        repeat (6) tick();
        reset = 1'b1;
        play_req = 4'b1111;
        tick();
        audio_out_allowed = 1'b1;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_addr", 64'(rom_addr), 64'(0));
        chk("midrst_write", 64'(write_audio_out), 64'(0));
        chk("midrst_clip", 64'(active_clip), 64'(0));
        chk("midrst_done", 64'(done), 64'(0));
        chk("midrst_left", 64'(left_channel_audio_out), 64'(0));
        reset = 1'b0;
        play_req = 4'b0000;
        repeat (20) begin
            tick();
            chk("midrst_stays_idle", 64'(busy), 64'(0));
        end

        // Arbitration over random request patterns, first samples of each grant
        for (int it = 0; it < 8; it++) begin
            req = (it == 0) ? 4'b0110 : 4'($urandom_range(1, 15));
            idx = 0;
            while (!req[idx]) idx++;
            play_req = req;
            tick();
            play_req = 4'b0000;
            tick();
            chk("arb_clip", 64'(active_clip), 64'(idx));
            chk("arb_start", 64'(rom_addr), 64'(starts[idx]));
            chk("arb_busy", 64'(busy), 64'(1));
            exp_q.delete();
            for (int a = starts[idx]; a < starts[idx] + 5; a++) exp_q.push_back(AW'(a));
            due = cyc + SD - 1;
            armed = 1'b1;
            repeat (5 * SD + 3) tick();
            chk("arb_writes_drained", 64'(exp_q.size()), 64'(0));
            armed = 1'b0;
            reset = 1'b1;
            tick();
            reset = 1'b0;
        end
        repeat (5) begin
            tick();
            chk("final_idle", 64'(busy), 64'(0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
